// File: rtl/seg7_bcd_decoder.sv
// Decodes a two-digit seven-segment word plus hundreds flag back into BCD digits and a binary value.
// Latency: word accepted at edge N, results and out_valid present after edge N+3.
// Backpressure: in_ready only in IDLE; results held in DONE until out_ready is seen.
module seg7_bcd_decoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] seg_0,
  input  logic [6:0] seg_1,
  input  logic       ov_flag,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] bcd_0,
  output logic [3:0] bcd_1,
  output logic [7:0] bin,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, DEC, MUL, SUM, DONE} state_t;

  state_t     state;
  logic [6:0] seg0_q;
  logic [6:0] seg1_q;
  logic       ov_q;
  logic [3:0] dig0_q;
  logic [3:0] dig1_q;
  logic       err0_q;
  logic       err1_q;
  logic [6:0] t10_q;

  logic [6:0] seg0_lit;
  logic [6:0] seg1_lit;
  logic [3:0] dig0_dec;
  logic [3:0] dig1_dec;
  logic [7:0] sum_val;

  // Segment pattern to digit; 4'hF marks any pattern that is not a legal digit.
  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    logic [3:0] d;
    case (s)
      7'b1111110: d = 4'd0;
      7'b0110000: d = 4'd1;
      7'b1101101: d = 4'd2;
      7'b1111001: d = 4'd3;
      7'b0110011: d = 4'd4;
      7'b1011011: d = 4'd5;
      7'b1011111: d = 4'd6;
      7'b1110000: d = 4'd7;
      7'b1111111: d = 4'd8;
      7'b1111011: d = 4'd9;
      default:    d = 4'hF;
    endcase
    return d;
  endfunction

  // Normalise captured segments to "1 = lit", decode them, and form the final sum.
  always_comb begin
    seg0_lit = SEG_ACTIVE_LOW ? ~seg0_q : seg0_q;
    seg1_lit = SEG_ACTIVE_LOW ? ~seg1_q : seg1_q;
    dig0_dec = seg_decode(seg0_lit);
    dig1_dec = seg_decode(seg1_lit);
    sum_val  = {1'b0, t10_q} + {4'd0, dig0_q} + (ov_q ? 8'd100 : 8'd0);
  end

  // Control FSM; every output is a register so results change only at the SUM edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bcd_0     <= 4'd0;
      bcd_1     <= 4'd0;
      bin       <= 8'd0;
      err       <= 1'b0;
      seg0_q    <= 7'd0;
      seg1_q    <= 7'd0;
      ov_q      <= 1'b0;
      dig0_q    <= 4'd0;
      dig1_q    <= 4'd0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      t10_q     <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            seg0_q   <= seg_0;
            seg1_q   <= seg_1;
            ov_q     <= ov_flag;
            in_ready <= 1'b0;
            state    <= DEC;
          end
        end
        DEC: begin
          dig0_q <= dig0_dec;
          dig1_q <= dig1_dec;
          err0_q <= (dig0_dec == 4'hF);
          err1_q <= (dig1_dec == 4'hF);
          state  <= MUL;
        end
        MUL: begin
          // x*10 as x*8 + x*2; an illegal digit (15) gives garbage that SUM discards.
          t10_q <= {dig1_q, 3'b000} + {2'b00, dig1_q, 1'b0};
          state <= SUM;
        end
        SUM: begin
          bcd_0     <= dig0_q;
          bcd_1     <= dig1_q;
          err       <= err0_q | err1_q;
          bin       <= (err0_q | err1_q) ? 8'hFF : sum_val;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_bcd_decoder.sv
// Scoreboard bench for seg7_bcd_decoder: random and directed words, reference model by table lookup.
// Also covers backpressure hold, mid-operation reset and an active-low instance.
// A monitor pops expected results whenever out_valid first appears.
module tb_seg7_bcd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, ov_flag, out_valid, out_ready, err;
  logic [6:0] seg_0, seg_1;
  logic [3:0] bcd_0, bcd_1;
  logic [7:0] bin;

  logic       lo_in_valid, lo_in_ready, lo_ov_flag, lo_out_valid, lo_err;
  logic [6:0] lo_seg_0, lo_seg_1;
  logic [3:0] lo_bcd_0, lo_bcd_1;
  logic [7:0] lo_bin;

  always #5 clk = ~clk;

  seg7_bcd_decoder #(.SEG_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .seg_0(seg_0), .seg_1(seg_1), .ov_flag(ov_flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .bcd_0(bcd_0), .bcd_1(bcd_1), .bin(bin), .err(err));

  seg7_bcd_decoder #(.SEG_ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk(clk), .rst(rst), .in_valid(lo_in_valid), .in_ready(lo_in_ready),
    .seg_0(lo_seg_0), .seg_1(lo_seg_1), .ov_flag(lo_ov_flag),
    .out_valid(lo_out_valid), .out_ready(1'b1),
    .bcd_0(lo_bcd_0), .bcd_1(lo_bcd_1), .bin(lo_bin), .err(lo_err));

  typedef struct {
    int b0;
    int b1;
    int bn;
    int er;
    int acc;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;

  // Digit glyphs a..g, 1 = lit, indexed by digit value.
  logic [6:0] glyph [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int ref_digit(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (glyph[i] == p) return i;
    return 15;
  endfunction

  function automatic exp_t model(input logic [6:0] s1, input logic [6:0] s0, input logic ov, input int acc);
    exp_t e;
    e.b1  = ref_digit(s1);
    e.b0  = ref_digit(s0);
    e.er  = (e.b0 == 15 || e.b1 == 15) ? 1 : 0;
    e.bn  = e.er ? 255 : (ov ? 100 : 0) + e.b1 * 10 + e.b0;
    e.acc = acc;
    return e;
  endfunction

  function automatic logic [6:0] rand_pattern();
    if ($urandom_range(0, 4) == 0) return 7'($urandom);
    return glyph[$urandom_range(0, 9)];
  endfunction

  // Monitor: pop on the first cycle of each out_valid, then check it holds and in_ready stays low.
  bit   seen = 1'b0;
  bit   prev_hs = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (rst) begin
      seen    = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) begin
        check("out_valid_clear", int'(out_valid), 0);
        check("in_ready_after_hs", int'(in_ready), 1);
      end
      if (out_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
            cur.b0 = int'(bcd_0); cur.b1 = int'(bcd_1); cur.bn = int'(bin); cur.er = int'(err);
          end else begin
            cur = q.pop_front();
            check("latency", cyc, cur.acc + 3);
            check("bcd_0", int'(bcd_0), cur.b0);
            check("bcd_1", int'(bcd_1), cur.b1);
            check("bin", int'(bin), cur.bn);
            check("err", int'(err), cur.er);
          end
          seen = 1'b1;
        end else begin
          check("hold_bcd_0", int'(bcd_0), cur.b0);
          check("hold_bcd_1", int'(bcd_1), cur.b1);
          check("hold_bin", int'(bin), cur.bn);
          check("hold_err", int'(err), cur.er);
        end
        check("in_ready_low_done", int'(in_ready), 0);
      end else begin
        seen = 1'b0;
      end
      prev_hs = out_valid && out_ready;
    end
  end

  // Randomised consumer readiness during the random phase.
  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [6:0] s1, input logic [6:0] s0, input logic ov, input bit expect_out);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      return;
    end
    seg_1 = s1; seg_0 = s0; ov_flag = ov; in_valid = 1'b1;
    if (expect_out) q.push_back(model(s1, s0, ov, cyc + 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seg_1 = 7'($urandom); seg_0 = 7'($urandom); ov_flag = 1'($urandom);
  endtask

  task automatic drain();
    int waited = 0;
    while ((q.size() != 0 || out_valid) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("drain_timeout", (q.size() != 0 || out_valid) ? 1 : 0, 0);
  endtask

  task automatic lo_run(input logic [6:0] s1, input logic [6:0] s0, input logic ov);
    exp_t e;
    int   waited = 0;
    e = model(~s1, ~s0, ov, 0);
    @(negedge clk);
    lo_seg_1 = s1; lo_seg_0 = s0; lo_ov_flag = ov; lo_in_valid = 1'b1;
    @(posedge clk);
    #1;
    lo_in_valid = 1'b0; lo_seg_1 = 7'($urandom); lo_seg_0 = 7'($urandom);
    while (!lo_out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("lo_out_valid", int'(lo_out_valid), 1);
    check("lo_bcd_0", int'(lo_bcd_0), e.b0);
    check("lo_bcd_1", int'(lo_bcd_1), e.b1);
    check("lo_bin", int'(lo_bin), e.bn);
    check("lo_err", int'(lo_err), e.er);
    @(negedge clk);
  endtask

  initial begin
    int waited;
    rst = 1'b1; in_valid = 1'b0; seg_0 = '0; seg_1 = '0; ov_flag = 1'b0; out_ready = 1'b1;
    lo_in_valid = 1'b0; lo_seg_0 = '0; lo_seg_1 = '0; lo_ov_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_bin", int'(bin), 0);
    check("rst_err", int'(err), 0);
    check("rst_bcd", int'({bcd_1, bcd_0}), 0);

    // Directed words from the plan.
    send(7'b0110000, 7'b1111001, 1'b0, 1'b1);
    drain();
    send(7'b1111011, 7'b1111111, 1'b1, 1'b1);
    drain();
    send(7'b1011011, 7'b0000000, 1'b0, 1'b1);
    drain();
    send(7'b0000000, 7'b1111001, 1'b1, 1'b1);
    drain();

    // Backpressure: hold out_ready low 10 cycles with in_valid asserted.
    out_ready = 1'b0;
    send(7'b1101101, 7'b1011111, 1'b1, 1'b1);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("bp_out_valid", int'(out_valid), 1);
    repeat (10) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; seg_1 = 7'($urandom); seg_0 = 7'($urandom);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_released_valid", int'(out_valid), 0);
    check("bp_released_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    drain();

    // Reset during MUL aborts the word.
    send(7'b1110000, 7'b0110011, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_bin", int'(bin), 0);
    check("abort_err", int'(err), 0);
    check("abort_bcd", int'({bcd_1, bcd_0}), 0);
    repeat (6) @(negedge clk);
    send(7'b1111110, 7'b1011011, 1'b0, 1'b1);
    drain();

    // Random words with random consumer readiness.
    rand_rdy = 1'b1;
    repeat (60) send(rand_pattern(), rand_pattern(), 1'($urandom), 1'b1);
    drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Active-low instance.
    lo_run(7'b1001111, 7'b0100100, 1'b1);
    lo_run(7'b1111111, 7'b0000001, 1'b0);
    repeat (6) lo_run(~glyph[$urandom_range(0, 9)], ~glyph[$urandom_range(0, 9)], 1'($urandom));

    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg7_bcd_decoder.md
# seg7_bcd_decoder

Receive-side decoder for the BCD adder's display outputs. Accepts one two-digit seven-segment word plus the hundreds overflow flag per handshake and recovers the two BCD digits and the binary value (0–199). Flags any segment pattern that is not a legal digit. Sits on the checker/readback path after the BCD adder, so results can be compared numerically instead of segment by segment.

## Interface
- SEG_ACTIVE_LOW, default 0: when 1, the segment inputs are inverted before decoding (a 0 bit means the segment is lit).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  seg_0/seg_1/ov_flag are valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- seg_0  input  7  ones-digit segments, bit6..bit0 = a,b,c,d,e,f,g; 1 = lit.
- seg_1  input  7  tens-digit segments, same bit order.
- ov_flag  input  1  hundreds carry; adds 100 to the result.
- out_valid  output  1  result registers are valid; held until out_ready.
- out_ready  input  1  consumer accepts the result.
- bcd_0  output  4  decoded ones digit; 4'hF if the pattern is illegal.
- bcd_1  output  4  decoded tens digit; 4'hF if the pattern is illegal.
- bin  output  8  ov_flag*100 + bcd_1*10 + bcd_0; 8'hFF if err.
- err  output  1  at least one digit pattern is illegal.

## Operation
- Legal digit patterns, after the optional inversion:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - Every other pattern is illegal, including blank (0000000).
- FSM states are IDLE, DEC, MUL, SUM, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: register seg_0, seg_1 and ov_flag, then go to DEC.
- DEC:
  - Decode both registered words into the bcd_0/bcd_1 registers.
  - Set an internal error bit per digit.
  - Go to MUL.
- MUL:
  - Register t10 = (bcd_1<<3) + (bcd_1<<1), 7 bits.
  - Go to SUM.
- SUM:
  - With no error: bin = t10 + bcd_0 + (ov ? 100 : 0), 8 bits. The maximum is 199, so it never wraps.
  - With any error: bin = 8'hFF and err = 1.
  - Set out_valid = 1 and go to DONE.
- DONE:
  - Hold all outputs stable while out_ready = 0.
  - On out_ready: clear out_valid and go to IDLE.
  - in_valid is ignored in DONE; no new word is accepted in the same cycle.
- bcd_0/bcd_1 show 4'hF only for the digit that is illegal. A legal digit shows its value even when the other digit is illegal.
- ov_flag with an illegal digit still gives bin = 8'hFF.

## Timing
- Reset (synchronous, checked at the rising edge while rst = 1):
  - State goes to IDLE.
  - out_valid = 0, err = 0, bcd_0 = 0, bcd_1 = 0, bin = 0, all internal registers = 0.
  - in_ready = 1 in the first cycle after reset.
- Latency: word accepted at edge N -> DEC at N, MUL at N+1, SUM at N+2, out_valid = 1 and results valid after edge N+3.
- in_ready drops after the accepting edge. It stays low until the edge where DONE sees out_ready.
- Throughput: at most one word per 5 cycles when out_ready is held high (accept, DEC, MUL, SUM, DONE).
- Input words may change freely after the accepting edge; only the captured copy is used.
- Reset mid-operation (DEC/MUL/SUM/DONE) aborts the word. No out_valid pulse is produced, and the next cycle is IDLE with reset values.
- err, bcd_*, bin and out_valid update together at edge N+3 and never glitch between handshakes.
- out_ready high outside DONE has no effect.

## Test plan
- Digits 1 and 3, ov = 0 (seg_1 = 0110000, seg_0 = 1111001) -> bcd_1 = 1, bcd_0 = 3, bin = 13, err = 0, out_valid 3 edges after accept.
- 99+99 result: ov = 1, seg_1 = 1111011 (9), seg_0 = 1111111 (8) -> bcd_1 = 9, bcd_0 = 8, bin = 198, err = 0.
- Illegal ones digit: seg_1 = 1011011 (5), seg_0 = 0000000 -> bcd_1 = 5, bcd_0 = F, bin = 8'hFF, err = 1.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after out_valid; outputs stay stable and in_ready stays 0, even with in_valid = 1.
  - Then pulse out_ready for one cycle -> out_valid = 0 and in_ready = 1 on the next cycle.
- Reset mid-operation:
  - Accept digits 7 and 4 (seg_1 = 1110000, seg_0 = 0110011), then assert rst in the MUL cycle.
  - Required: no out_valid; after reset all outputs are 0 and in_ready = 1.
  - A following word with digits 0 and 5 (seg_1 = 1111110, seg_0 = 1011011) decodes to bin = 5.
- SEG_ACTIVE_LOW = 1: seg_1 = 1001111 (1), seg_0 = 0100100 (5), ov = 1 -> bin = 115, err = 0.
